// File: rtl/rsa_modexp_seq.sv
// Bit-serial modular exponentiation (square-and-multiply, Blakley interleaved multiply).
// Define RSA_CONST_TIME_EN to run MUL on every exponent bit for exponent-independent latency.
module rsa_modexp_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EXP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 ready,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned EW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
`ifdef RSA_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_SQR, S_MUL, S_FIN} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     base_q, n_q, r_q, bp_q, acc_q, result_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [CW-1:0]        cnt_q;
  logic [EW-1:0]        eidx_q;
  logic                 ready_q, done_q, error_q;

  logic             mod_bad, op_last, bit_last, e_bit;
  logic             a_bit, wr_r;
  logic [WIDTH-1:0] y_op, dbl_r, red, r_next;
  logic [WIDTH:0]   dbl, sum;

  assign mod_bad  = (modulus < WIDTH'(2));
  assign op_last  = (cnt_q == '0);
  assign bit_last = (eidx_q == '0);
  assign e_bit    = e_q[eidx_q];

  always_ff @(posedge clk) begin : state_reg
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = mod_bad ? S_FIN : S_REDUCE;
      S_REDUCE: if (op_last) state_d = S_SQR;
      S_SQR: begin
        if (op_last) begin
          if (CONST_TIME || e_bit) state_d = S_MUL;
          else if (bit_last)       state_d = S_FIN;
          else                     state_d = S_SQR;
        end
      end
      S_MUL:    if (op_last) state_d = bit_last ? S_FIN : S_SQR;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Operand selection for the Blakley step: multiplier bit a_bit, addend y_op.
  always_comb begin : output_decode
    a_bit = 1'b0;
    y_op  = '0;
    wr_r  = 1'b0;
    case (state_q)
      S_REDUCE: begin
        a_bit = base_q[cnt_q];
        y_op  = WIDTH'(1);
      end
      S_SQR: begin
        a_bit = r_q[cnt_q];
        y_op  = r_q;
        wr_r  = 1'b1;
      end
      S_MUL: begin
        a_bit = r_q[cnt_q];
        y_op  = bp_q;
        wr_r  = e_bit;
      end
      default: ;
    endcase
  end

  // acc = 2*acc mod n, then (acc + y) mod n; each mod is a single conditional subtract.
  always_comb begin : blakley_step
    dbl    = {acc_q, 1'b0};
    dbl_r  = (dbl >= {1'b0, n_q}) ? WIDTH'(dbl - {1'b0, n_q}) : dbl[WIDTH-1:0];
    sum    = {1'b0, dbl_r} + (a_bit ? {1'b0, y_op} : '0);
    red    = (sum >= {1'b0, n_q}) ? WIDTH'(sum - {1'b0, n_q}) : sum[WIDTH-1:0];
    r_next = wr_r ? red : r_q;
  end

  always_ff @(posedge clk) begin : datapath
    if (!rst) begin
      base_q   <= '0;
      n_q      <= '0;
      e_q      <= '0;
      r_q      <= '0;
      bp_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      eidx_q   <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == S_IDLE);
      done_q  <= (state_d == S_FIN);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q  <= base;
            e_q     <= exponent;
            n_q     <= modulus;
            error_q <= mod_bad;
            acc_q   <= '0;
            r_q     <= WIDTH'(1);
            cnt_q   <= CW'(WIDTH - 1);
            eidx_q  <= EW'(EXP_WIDTH - 1);
            if (mod_bad) result_q <= '0;
          end
        end
        S_REDUCE, S_SQR, S_MUL: begin
          acc_q <= op_last ? '0 : red;
          cnt_q <= op_last ? CW'(WIDTH - 1) : cnt_q - CW'(1);
          if (op_last) begin
            if (state_q == S_REDUCE) bp_q <= red;
            else                     r_q  <= r_next;
            if (state_q != S_REDUCE && state_d == S_SQR) eidx_q <= eidx_q - EW'(1);
            if (state_d == S_FIN) result_q <= r_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign error  = error_q;

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Directed checks of rsa_modexp_seq: results, error flag, latency, handshake and reset abort.
module tb_rsa_modexp_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base, exponent, modulus;
  logic       ready, done, error;
  logic [7:0] result;

  int n_chk = 0;
  int n_bad = 0;

  rsa_modexp_seq #(.WIDTH(8), .EXP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .ready(ready), .result(result), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_modexp(input int b, input int e, input int n);
    longint r = 1;
    longint bb = b % n;
    for (int i = 7; i >= 0; i--) begin
      r = (r * r) % n;
      if (e[i]) r = (r * bb) % n;
    end
    return int'(r);
  endfunction

  function automatic int exp_latency(input int e, input int n);
    int k;
    if (n < 2) return 1;
`ifdef RSA_CONST_TIME_EN
    k = 8;
`else
    k = $countones(e[7:0]);
`endif
    return 8 + 8 * 8 + k * 8 + 1;
  endfunction

  // One request; with hold=1 start stays high with other operands for the whole run.
  task automatic do_op(input string tag, input logic [7:0] b, input logic [7:0] e,
                       input logic [7:0] n, input bit hold, input int exp_res,
                       input int exp_err, output logic [7:0] res);
    int lat;
    int rdy_hi;
    base = b; exponent = e; modulus = n; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = 1;
    rdy_hi = 0;
    while (!done && lat < 3000) begin
      if (ready) rdy_hi++;
      if (hold) begin
        base = 8'(lat); exponent = 8'hFF; modulus = 8'd13;
      end
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    chk({tag, "_done_seen"}, int'(done), 1);
    chk({tag, "_latency"}, lat, exp_latency(int'(e), int'(n)));
    chk({tag, "_result"}, int'(result), exp_res);
    chk({tag, "_error"}, int'(error), exp_err);
    chk({tag, "_ready_low"}, rdy_hi, 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_ready_back"}, int'(ready), 1);
    chk({tag, "_result_held"}, int'(result), exp_res);
  endtask

  initial begin
    logic [7:0] r1, r2;
    int rb, re, rn;
    rst = 1'b0; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_error", int'(error), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op("enc", 8'd88, 8'd7, 8'd187, 1'b0, 11, 0, r1);
    do_op("dec", r1, 8'd23, 8'd187, 1'b0, 88, 0, r2);
    do_op("base_gt_n", 8'd200, 8'd1, 8'd187, 1'b0, 13, 0, r1);
    do_op("exp0", 8'd5, 8'd0, 8'd187, 1'b0, 1, 0, r1);
    do_op("base0", 8'd0, 8'd5, 8'd187, 1'b0, 0, 0, r1);
    do_op("small", 8'd3, 8'd4, 8'd7, 1'b0, 4, 0, r1);
    do_op("pow2", 8'd2, 8'd10, 8'd255, 1'b0, 4, 0, r1);
    do_op("minus1", 8'd250, 8'd3, 8'd251, 1'b0, 250, 0, r1);
    do_op("n2", 8'd255, 8'd255, 8'd2, 1'b0, 1, 0, r1);
    do_op("mod1", 8'd9, 8'd3, 8'd1, 1'b0, 0, 1, r1);
    do_op("clr_err1", 8'd7, 8'd2, 8'd13, 1'b0, 10, 0, r1);
    do_op("mod0", 8'd9, 8'd3, 8'd0, 1'b0, 0, 1, r1);
    do_op("clr_err0", 8'd88, 8'd7, 8'd187, 1'b0, 11, 0, r1);
    do_op("hold_start", 8'd11, 8'd23, 8'd187, 1'b1, 88, 0, r1);

    // Reset while squaring: the run is discarded without a done pulse.
    base = 8'd88; exponent = 8'd7; modulus = 8'd187; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", int'(ready), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", int'(done), 0);
    end
    do_op("after_abort", 8'd11, 8'd23, 8'd187, 1'b0, 88, 0, r1);

    for (int i = 0; i < 150; i++) begin
      rb = int'($urandom_range(255));
      re = int'($urandom_range(255));
      rn = int'($urandom_range(255, 2));
      do_op("rand", 8'(rb), 8'(re), 8'(rn), 1'b0, ref_modexp(rb, re, rn), 0, r1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
